digit_scanner: RTL and testbench

DIGIT_SCANNER -- requirements
Module: digit_scanner

---
 rtl/digit_scanner_if.sv | 27 ++
 rtl/digit_scanner.sv | 85 ++++++++
 tb/tb_digit_scanner.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/digit_scanner_if.sv
// Display-scanner bus: value/control toward the scanner, digit drive back out.
interface digit_scanner_if;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  number;
    logic [3:0]  anodes;
    logic        frame_done;

    modport master (
        output value,
        output load,
        output blank_lz,
        input  number,
        input  anodes,
        input  frame_done
    );

    modport slave (
        input  value,
        input  load,
        input  blank_lz,
        output number,
        output anodes,
        output frame_done
    );
endinterface

// File: rtl/digit_scanner.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous display update
// (no tearing) and optional leading-zero blanking.
module digit_scanner #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    digit_scanner_if.slave  bus
);
    localparam int unsigned         CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_shadow;
    logic [15:0]      r_disp;
    logic             r_pending;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_frame_end;
    logic [3:0]       w_digit;
    logic             w_z1;
    logic             w_z2;
    logic             w_z3;
    logic [3:0]       w_lead_zero;
    logic             w_slot_blank;

    assign w_tick      = (r_cnt == CNT_MAX);
    assign w_frame_end = w_tick && (r_idx == 2'd3);

    // Prescaler, digit index, shadow/display update and frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_shadow     <= 16'h0000;
            r_disp       <= 16'h0000;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_frame_done <= w_frame_end;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            if (bus.load) begin
                r_shadow <= bus.value;
            end
            if (w_frame_end) begin
                // A load on the boundary itself bypasses the shadow so it is not
                // left pending for a whole extra frame.
                r_pending <= 1'b0;
                if (bus.load) begin
                    r_disp <= bus.value;
                end else if (r_pending) begin
                    r_disp <= r_shadow;
                end
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_digit = r_disp[{r_idx, 2'b00} +: 4];

    // Digit i is a leading zero when nibbles i..3 are all zero; digit 0 always shows
    assign w_z3        = (r_disp[15:12] == 4'h0);
    assign w_z2        = (r_disp[11:8]  == 4'h0);
    assign w_z1        = (r_disp[7:4]   == 4'h0);
    assign w_lead_zero = {w_z3, w_z3 & w_z2, w_z3 & w_z2 & w_z1, 1'b0};
    assign w_slot_blank = bus.blank_lz && w_lead_zero[r_idx];

    // Digit drive: selected nibble and one-hot-low anode, or fully off when blanked
    always_comb begin
        bus.number = w_digit;
        bus.anodes = ~(4'b0001 << r_idx);
        if (w_slot_blank) begin
            bus.number = 4'h0;
            bus.anodes = 4'b1111;
        end
    end

    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with REFRESH_DIV=4 (16-cycle frames).
module tb_digit_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   tcnt;   // rising edges since the last reset release

    digit_scanner_if u_if ();

    digit_scanner #(
        .REFRESH_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, tcnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        tcnt += n;
    endtask

    task automatic go_to(input int t);
        step(t - tcnt);
    endtask

    task automatic slot(input string tag, input logic [3:0] num, input logic [3:0] an);
        check({tag, ".number"}, {12'h0, u_if.number}, {12'h0, num});
        check({tag, ".anodes"}, {12'h0, u_if.anodes}, {12'h0, an});
    endtask

    task automatic load_val(input logic [15:0] v);
        u_if.value = v;
        u_if.load  = 1'b1;
        step(1);
        u_if.load  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        tcnt     = 0;
        rst      = 1'b1;
        u_if.value    = 16'h0000;
        u_if.load     = 1'b0;
        u_if.blank_lz = 1'b0;

        // Reset and free-running scan
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        tcnt = 0;
        slot("rst", 4'h0, 4'b1110);
        check("rst.frame_done", {15'h0, u_if.frame_done}, 16'h0);
        go_to(4);  slot("scan4", 4'h0, 4'b1101);
        go_to(8);  slot("scan8", 4'h0, 4'b1011);
        go_to(12); slot("scan12", 4'h0, 4'b0111);
        go_to(15); check("fd_before", {15'h0, u_if.frame_done}, 16'h0);
        go_to(16); slot("scan16", 4'h0, 4'b1110);
        check("fd_pulse", {15'h0, u_if.frame_done}, 16'h1);
        go_to(17); check("fd_one_cycle", {15'h0, u_if.frame_done}, 16'h0);

        // Load mid-frame: held until the frame boundary
        go_to(20);
        load_val(16'h12AF);
        slot("latch_hold1", 4'h0, 4'b1101);
        go_to(31); slot("latch_hold3", 4'h0, 4'b0111);
        go_to(32); slot("latch_d0", 4'hF, 4'b1110);
        check("latch_fd", {15'h0, u_if.frame_done}, 16'h1);
        go_to(36); slot("latch_d1", 4'hA, 4'b1101);
        go_to(40); slot("latch_d2", 4'h2, 4'b1011);
        go_to(44); slot("latch_d3", 4'h1, 4'b0111);
        go_to(47); check("fd_gap", {15'h0, u_if.frame_done}, 16'h0);
        go_to(48); check("fd_next", {15'h0, u_if.frame_done}, 16'h1);

        // Last load in a frame wins
        go_to(49);
        load_val(16'h1111);
        load_val(16'h2222);
        go_to(52); slot("lw_notear", 4'hA, 4'b1101);
        go_to(60); slot("lw_notear3", 4'h1, 4'b0111);
        go_to(64); slot("lw_d0", 4'h2, 4'b1110);
        go_to(68); slot("lw_d1", 4'h2, 4'b1101);
        go_to(72); slot("lw_d2", 4'h2, 4'b1011);
        go_to(76); slot("lw_d3", 4'h2, 4'b0111);

        // Leading-zero blanking
        go_to(77);
        u_if.blank_lz = 1'b1;
        load_val(16'h0050);
        go_to(80); slot("blk_d0", 4'h0, 4'b1110);
        go_to(84); slot("blk_d1", 4'h5, 4'b1101);
        go_to(88); slot("blk_d2", 4'h0, 4'b1111);
        go_to(92); slot("blk_d3", 4'h0, 4'b1111);
        u_if.blank_lz = 1'b0;
        #1;
        slot("blk_off_d3", 4'h0, 4'b0111);
        go_to(96); slot("blk_off_d0", 4'h0, 4'b1110);
        go_to(104); slot("blk_off_d2", 4'h0, 4'b1011);

        // Load coinciding with the frame-boundary tick
        go_to(111);
        load_val(16'hBEEF);
        slot("bnd_d0", 4'hF, 4'b1110);
        check("bnd_pending", {15'h0, dut.r_pending}, 16'h0);
        go_to(116); slot("bnd_d1", 4'hE, 4'b1101);
        go_to(124); slot("bnd_d3", 4'hB, 4'b0111);

        // Reset mid-frame with a pending load; rst also beats a concurrent load
        go_to(129);
        load_val(16'h1234);
        go_to(136); slot("mr_pre", 4'hE, 4'b1011);
        rst = 1'b1;
        u_if.value = 16'hFFFF;
        u_if.load  = 1'b1;
        step(1);
        rst = 1'b0;
        u_if.load = 1'b0;
        tcnt = 0;
        slot("mr_rst", 4'h0, 4'b1110);
        check("mr_fd", {15'h0, u_if.frame_done}, 16'h0);
        go_to(4);  slot("mr_d1", 4'h0, 4'b1101);
        go_to(12); slot("mr_d3", 4'h0, 4'b0111);
        go_to(16); slot("mr_next", 4'h0, 4'b1110);
        check("mr_fd_next", {15'h0, u_if.frame_done}, 16'h1);
        go_to(28); slot("mr_next_d3", 4'h0, 4'b0111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
